// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared FSM state type and access-size constant for the memory copy initiator
// The ERR state exists only when MEM_COPY_INITIATOR_TIMEOUT_EN is defined.
package mem_copy_pkg;

   localparam int MEM_BYTE_SIZE = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      DONE
`ifdef MEM_COPY_INITIATOR_TIMEOUT_EN
      , ERR
`endif
   } state_e;

endpackage

// File: rtl/mem_copy_watchdog.sv
// rtl/mem_copy_watchdog.sv - per-access wait counter, used only when MEM_COPY_INITIATOR_TIMEOUT_EN is defined
// expired_o fires in the cycle that would be the TIMEOUT_CYCLES-th consecutive unacknowledged cycle.
module mem_copy_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic active_i,
   input  logic ack_i,
   output logic expired_o
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired_o = active_i && !ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (active_i && !ack_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_copy_initiator.sv
// rtl/mem_copy_initiator.sv - byte-at-a-time memory copy master (read, then write, per byte)
// Optional MEM_COPY_INITIATOR_TIMEOUT_EN bounds each access and reports error_port.
module mem_copy_initiator
   import mem_copy_pkg::*;
#(
   parameter int ADDR_W         = 7,
   parameter int LEN_W          = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_port,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              done_port,
`ifdef MEM_COPY_INITIATOR_TIMEOUT_EN
   output logic              error_port,
`endif
   output logic              Mout_oe_ram,
   output logic              Mout_we_ram,
   output logic [ADDR_W-1:0] Mout_addr_ram,
   output logic [7:0]        Mout_Wdata_ram,
   output logic [3:0]        Mout_data_ram_size,
   input  logic [7:0]        M_Rdata_ram,
   input  logic              M_DataRdy
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [7:0]        data_q, data_d;

`ifdef MEM_COPY_INITIATOR_TIMEOUT_EN
   logic in_access;
   logic timeout_hit;

   assign in_access = (state_q == RD) || (state_q == WR);

   mem_copy_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock    (clock),
      .reset    (reset),
      .active_i (in_access),
      .ack_i    (M_DataRdy),
      .expired_o(timeout_hit)
   );
`else
   // Waits are unbounded in this build; TIMEOUT_CYCLES only feeds the watchdog build.
   if (TIMEOUT_CYCLES > 0) begin : g_unbounded_wait
   end
`endif

   always_comb begin
      state_d            = state_q;
      src_d              = src_q;
      dst_d              = dst_q;
      rem_d              = rem_q;
      data_d             = data_q;
      done_port          = 1'b0;
`ifdef MEM_COPY_INITIATOR_TIMEOUT_EN
      error_port         = 1'b0;
`endif
      Mout_oe_ram        = 1'b0;
      Mout_we_ram        = 1'b0;
      Mout_addr_ram      = '0;
      Mout_Wdata_ram     = '0;
      Mout_data_ram_size = '0;

      case (state_q)
         IDLE: begin
            if (start_port) begin
               src_d   = src_addr;
               dst_d   = dst_addr;
               rem_d   = length;
               state_d = (length != '0) ? RD : DONE;
            end
         end
         RD: begin
            Mout_oe_ram        = 1'b1;
            Mout_addr_ram      = src_q;
            Mout_data_ram_size = 4'(MEM_BYTE_SIZE);
`ifdef MEM_COPY_INITIATOR_TIMEOUT_EN
            if (timeout_hit) state_d = ERR;
            else
`endif
            if (M_DataRdy) begin
               data_d  = M_Rdata_ram;
               state_d = WR;
            end
         end
         WR: begin
            Mout_we_ram        = 1'b1;
            Mout_addr_ram      = dst_q;
            Mout_Wdata_ram     = data_q;
            Mout_data_ram_size = 4'(MEM_BYTE_SIZE);
`ifdef MEM_COPY_INITIATOR_TIMEOUT_EN
            if (timeout_hit) state_d = ERR;
            else
`endif
            if (M_DataRdy) begin
               // Addresses wrap at 2^ADDR_W by natural overflow.
               src_d   = src_q + 1'b1;
               dst_d   = dst_q + 1'b1;
               rem_d   = rem_q - 1'b1;
               state_d = (rem_q != LEN_W'(1)) ? RD : DONE;
            end
         end
         DONE: begin
            done_port = 1'b1;
            state_d   = IDLE;
         end
`ifdef MEM_COPY_INITIATOR_TIMEOUT_EN
         ERR: begin
            done_port  = 1'b1;
            error_port = 1'b1;
            state_d    = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
      end
   end

endmodule
